// File: rtl/fifo_drain.sv
// Drains up to len words from a fall-through FIFO into a valid/ready downstream port.
// The output stage is one register deep, and the next word is popped in the cycle the current
// one is accepted.
module fifo_drain #(
    parameter int unsigned DW = 4,
    parameter int unsigned LW = 8
) (
    input  logic          rclk,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [LW-1:0] len_i,
    input  logic          abort_i,
    input  logic          empty_i,
    input  logic [DW-1:0] fdat_i,
    output logic          ren_o,
    output logic          vld_o,
    output logic [DW-1:0] dat_o,
    input  logic          rdy_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [LW-1:0] cnt_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q, state_d;
    logic [LW-1:0] pop_left_q, pop_left_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          vld_q, vld_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          hs, last_hs, ren;

    assign hs      = vld_q & rdy_i;
    assign ren     = (state_q == StRun) & ~empty_i & (pop_left_q != '0) & (~vld_q | rdy_i)
                     & ~abort_i;
    // The handshake that completes the transfer; cnt_q < len_q in RUN, so no wrap.
    assign last_hs = hs & ((cnt_q + LW'(1)) == len_q);

    always_comb begin
        state_d    = state_q;
        pop_left_d = pop_left_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        vld_d      = vld_q;
        dat_d      = dat_q;

        if (hs) begin
            cnt_d = cnt_q + LW'(1);
        end

        if (ren) begin
            dat_d      = fdat_i;
            vld_d      = 1'b1;
            pop_left_d = pop_left_q - LW'(1);
        end else if (hs) begin
            vld_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    cnt_d      = '0;
                    len_d      = len_i;
                    pop_left_d = len_i;
                    state_d    = (len_i == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (abort_i) begin
                    // A word sitting in the output register is dropped, not delivered.
                    vld_d   = 1'b0;
                    state_d = StDone;
                end else if (last_hs) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge rclk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            pop_left_q <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            vld_q      <= 1'b0;
            dat_q      <= '0;
        end else begin
            state_q    <= state_d;
            pop_left_q <= pop_left_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            vld_q      <= vld_d;
            dat_q      <= dat_d;
        end
    end

    assign ren_o  = ren;
    assign vld_o  = vld_q;
    assign dat_o  = dat_q;
    assign busy_o = (state_q != StIdle);
    assign done_o = (state_q == StDone);
    assign cnt_o  = cnt_q;

endmodule

// File: tb/tb_fifo_drain.sv
// Self-checking bench for fifo_drain: queue-based FIFO model, scoreboard monitor on the falling
// edge, directed corner cases, a vector table and randomized transfers.
module tb_fifo_drain;

    localparam int DW = 4;
    localparam int LW = 8;

    logic          rclk = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic [LW-1:0] len_i;
    logic          abort_i;
    logic          empty_i;
    logic [DW-1:0] fdat_i;
    logic          ren_o;
    logic          vld_o;
    logic [DW-1:0] dat_o;
    logic          rdy_i;
    logic          busy_o;
    logic          done_o;
    logic [LW-1:0] cnt_o;

    fifo_drain #(.DW(DW), .LW(LW)) dut (
        .rclk    (rclk),
        .rst_ni  (rst_ni),
        .start_i (start_i),
        .len_i   (len_i),
        .abort_i (abort_i),
        .empty_i (empty_i),
        .fdat_i  (fdat_i),
        .ren_o   (ren_o),
        .vld_o   (vld_o),
        .dat_o   (dat_o),
        .rdy_i   (rdy_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .cnt_o   (cnt_o)
    );

    always #5 rclk = ~rclk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Fall-through FIFO model: head word is visible while non-empty.
    logic [DW-1:0] fifo[$];

    function automatic void drive_fifo();
        empty_i = (fifo.size() == 0);
        fdat_i  = (fifo.size() == 0) ? '0 : fifo[0];
    endfunction

    task automatic push(input logic [DW-1:0] w);
        fifo.push_back(w);
        drive_fifo();
    endtask

    task automatic settle();
        #1;
    endtask

    // One clock: sample the pop request, cross the edge, retire the popped word.
    task automatic step();
        logic r;
        #1;
        r = ren_o;
        @(posedge rclk);
        #1;
        if (r && fifo.size() > 0) void'(fifo.pop_front());
        start_i = 1'b0;
        drive_fifo();
    endtask

    task automatic wait_done(input int max, output int edges);
        int n;
        n = 0;
        edges = -1;
        while (n < max) begin
            step();
            n++;
            if (done_o) begin
                edges = n;
                return;
            end
        end
    endtask

    // Scoreboard: words popped from the FIFO must reach the output in order; an abort drops
    // whatever was popped but not yet accepted.
    logic [DW-1:0] exp_q[$];
    int            deliv = 0;
    int            pops = 0;
    int            exp_len = 0;
    bit            aborted = 1'b0;

    always @(negedge rclk) begin
        if (rst_ni) begin
            if (busy_o) chk("cnt_track", cnt_o, deliv);
            if (done_o) begin
                chk("done_cnt", cnt_o, deliv);
                if (!aborted) chk("done_len", cnt_o, exp_len);
                chk("done_flushed", exp_q.size(), 0);
            end
            if (vld_o && rdy_i) begin
                if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
                else chk("dat", dat_o, exp_q.pop_front());
                deliv++;
            end
            if (ren_o) begin
                chk("ren_nonempty", empty_i, 0);
                pops++;
                chk("pop_bound", (pops <= exp_len), 1);
                exp_q.push_back(fdat_i);
            end
            if (abort_i && busy_o && !done_o) begin
                exp_q.delete();
                aborted = 1'b1;
            end
            if (start_i && !busy_o) begin
                deliv   = 0;
                pops    = 0;
                exp_len = int'(len_i);
                aborted = 1'b0;
                exp_q.delete();
            end
        end else begin
            exp_q.delete();
        end
    end

    typedef struct {
        int len;
        int exp_edges;
        int exp_cnt;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  e, l, pre, pushed, n;
        bit  seen, dn;
        logic [DW-1:0] abc[3];

        tbl[0] = '{len: 1,   exp_edges: 3,   exp_cnt: 1};
        tbl[1] = '{len: 2,   exp_edges: 4,   exp_cnt: 2};
        tbl[2] = '{len: 4,   exp_edges: 6,   exp_cnt: 4};
        tbl[3] = '{len: 0,   exp_edges: 1,   exp_cnt: 0};
        tbl[4] = '{len: 9,   exp_edges: 11,  exp_cnt: 9};
        tbl[5] = '{len: 255, exp_edges: 257, exp_cnt: 255};

        rst_ni = 1'b1; start_i = 1'b0; len_i = '0; abort_i = 1'b0; rdy_i = 1'b0;
        drive_fifo();
        #1 rst_ni = 1'b0;
        #1;
        chk("rst_ren", ren_o, 0);
        chk("rst_vld", vld_o, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_cnt", cnt_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        @(posedge rclk);
        #1 rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_after_rst", busy_o, 0);
        end

        // Basic transfer A,B,C at full rate.
        abc[0] = 4'hA; abc[1] = 4'hB; abc[2] = 4'hC;
        push(4'hA); push(4'hB); push(4'hC);
        rdy_i = 1'b1; start_i = 1'b1; len_i = 8'd3;
        settle();
        chk("basic_ren_idle", ren_o, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("basic_ren", ren_o, 1);
            step();
            chk("basic_vld", vld_o, 1);
            chk("basic_dat", dat_o, abc[i]);
        end
        settle();
        chk("basic_ren_end", ren_o, 0);
        chk("basic_not_done", done_o, 0);
        step();
        chk("basic_done", done_o, 1);
        chk("basic_cnt", cnt_o, 3);
        step();
        chk("basic_done_pulse", done_o, 0);
        chk("basic_idle", busy_o, 0);
        chk("basic_cnt_hold", cnt_o, 3);

        // Backpressure: one pop, then hold the word until ready.
        fifo.delete(); push(4'h5); push(4'h6);
        rdy_i = 1'b0; start_i = 1'b1; len_i = 8'd2;
        step();
        settle();
        chk("bp_ren_first", ren_o, 1);
        step();
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("bp_ren_stall", ren_o, 0);
            chk("bp_vld", vld_o, 1);
            chk("bp_dat", dat_o, 4'h5);
            chk("bp_one_pop", fifo.size(), 1);
            step();
        end
        rdy_i = 1'b1;
        settle();
        chk("bp_ren_resume", ren_o, 1);
        step();
        chk("bp_dat2", dat_o, 4'h6);
        chk("bp_cnt1", cnt_o, 1);
        step();
        chk("bp_cnt2", cnt_o, 2);
        chk("bp_done", done_o, 1);
        step();

        // Underflow: stall on empty, then complete once data arrives.
        fifo.delete(); drive_fifo();
        start_i = 1'b1; len_i = 8'd2;
        step();
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("uf_ren", ren_o, 0);
            chk("uf_busy", busy_o, 1);
            step();
        end
        push(4'h3);
        settle();
        chk("uf_ren_go", ren_o, 1);
        step();
        chk("uf_dat", dat_o, 4'h3);
        push(4'h9);
        wait_done(10, e);
        chk("uf_done_seen", (e > 0), 1);
        chk("uf_cnt", cnt_o, 2);
        step();

        // Zero length, then a start during DONE that must be ignored.
        fifo.delete(); push(4'h7);
        start_i = 1'b1; len_i = 8'd0;
        settle();
        chk("zl_ren0", ren_o, 0);
        step();
        chk("zl_done", done_o, 1);
        chk("zl_cnt", cnt_o, 0);
        chk("zl_ren1", ren_o, 0);
        start_i = 1'b1; len_i = 8'd3;
        step();
        chk("zl_start_ignored", busy_o, 0);
        chk("zl_no_pop", fifo.size(), 1);

        // Abort after two handshakes with a third word held.
        fifo.delete();
        for (int i = 1; i <= 6; i++) push(DW'(i));
        rdy_i = 1'b1; start_i = 1'b1; len_i = 8'd5;
        for (int i = 0; i < 4; i++) step();
        chk("ab_cnt_pre", cnt_o, 2);
        chk("ab_dat_held", dat_o, 4'h3);
        rdy_i = 1'b0; abort_i = 1'b1;
        settle();
        chk("ab_ren", ren_o, 0);
        step();
        abort_i = 1'b0;
        chk("ab_vld", vld_o, 0);
        chk("ab_done", done_o, 1);
        chk("ab_cnt", cnt_o, 2);
        for (int i = 0; i < 3; i++) step();
        chk("ab_no_more_pops", fifo.size(), 3);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("ab_idle_no_effect", busy_o | done_o, 0);

        // Reset in the middle of a transfer.
        fifo.delete();
        for (int i = 1; i <= 4; i++) push(DW'(i));
        rdy_i = 1'b0; start_i = 1'b1; len_i = 8'd4;
        step();
        step();
        chk("rr_vld_before", vld_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("rr_vld", vld_o, 0);
        chk("rr_busy", busy_o, 0);
        chk("rr_cnt", cnt_o, 0);
        chk("rr_ren", ren_o, 0);
        step();
        step();
        rst_ni = 1'b1;
        dn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            dn = dn | done_o | busy_o;
        end
        chk("rr_no_done", dn, 0);

        // Table of full-rate transfers.
        rdy_i = 1'b1;
        for (int t = 0; t < 6; t++) begin
            fifo.delete();
            for (int k = 0; k < tbl[t].len; k++) push(DW'(k * 3 + 1));
            start_i = 1'b1; len_i = LW'(tbl[t].len);
            wait_done(tbl[t].len + 5, e);
            chk("tbl_edges", e, tbl[t].exp_edges);
            chk("tbl_cnt", cnt_o, tbl[t].exp_cnt);
            step();
            chk("tbl_idle", busy_o, 0);
        end

        // Randomized transfers with random ready, arrivals and occasional abort.
        for (int t = 0; t < 30; t++) begin
            l = $urandom_range(0, 12);
            pre = $urandom_range(0, l);
            fifo.delete();
            for (int k = 0; k < pre; k++) push(DW'($urandom));
            pushed = pre;
            start_i = 1'b1; len_i = LW'(l);
            n = 0; seen = 1'b0;
            while (n < 300 && !seen) begin
                abort_i = busy_o && !done_o && ($urandom_range(0, 39) == 0);
                rdy_i = ($urandom_range(0, 9) < 7);
                if (pushed < l + 1 && $urandom_range(0, 1) == 1) begin
                    push(DW'($urandom));
                    pushed++;
                end
                step();
                n++;
                if (done_o) seen = 1'b1;
            end
            abort_i = 1'b0;
            chk("rand_done", seen, 1);
            step();
            chk("rand_idle", busy_o, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
